// File: rtl/pixel_pack_pkg.sv
// Shared constants for the pixel stream packer: default packing factor,
// tag bit positions within a FIFO entry, and the entry-width helper.
package pixel_pack_pkg;

    localparam int PACK_DEFAULT = 4;

    localparam int TAG_SOF = 0;
    localparam int TAG_EOL = 1;
    localparam int TAG_EOF = 2;
    localparam int TAG_W   = 3;

    function automatic int entry_width(input int pack, input int data_width);
        return pack * data_width + TAG_W;
    endfunction

endpackage

// File: rtl/pack_fifo.sv
// Synchronous FIFO for packed words; a push into a full FIFO is accepted
// when a pop happens in the same cycle. rdata reads as zero while empty.
module pack_fifo #(
    parameter int WIDTH = 35,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push, do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = empty ? '0 : mem_q[rd_ptr_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clr) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/pixel_stream_packer.sv
// Packs PACK filtered pixels per word, tags sof/eol/eof from column/row
// position and buffers words in pack_fifo. Define PACKER_DROP_CNT_EN for drop_cnt.
module pixel_stream_packer
    import pixel_pack_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PACK       = PACK_DEFAULT,
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr,
    input  logic [DATA_WIDTH-1:0]      pix_in,
    input  logic                       pix_in_en,
    output logic [PACK*DATA_WIDTH-1:0] m_data,
    output logic                       m_sof,
    output logic                       m_eol,
    output logic                       m_eof,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic                       overflow,
    output logic                       frame_done
`ifdef PACKER_DROP_CNT_EN
    ,
    output logic [15:0]                drop_cnt
`endif
);
    localparam int WORD_W  = PACK * DATA_WIDTH;
    localparam int ENTRY_W = entry_width(PACK, DATA_WIDTH);
    localparam int COL_W   = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int ROW_W   = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam int LANE_W  = (PACK > 1) ? $clog2(PACK) : 1;

    logic [COL_W-1:0]      col_q, col_d;
    logic [ROW_W-1:0]      row_q, row_d;
    logic [LANE_W-1:0]     lane_q, lane_d;
    logic [DATA_WIDTH-1:0] hold_q [PACK-1];
    logic                  overflow_q, frame_done_q;

    logic               last_lane, col_last, row_last;
    logic               push_req, pop, drop, fifo_full, fifo_empty;
    logic [WORD_W-1:0]  word;
    logic [ENTRY_W-1:0] wdata, rdata;

    assign last_lane = (lane_q == LANE_W'(PACK - 1));
    assign col_last  = (col_q == COL_W'(IMG_WIDTH - 1));
    assign row_last  = (row_q == ROW_W'(IMG_HEIGHT - 1));
    assign push_req  = pix_in_en & ~clr & last_lane;
    assign pop       = m_valid & m_ready & ~clr;
    assign drop      = push_req & fifo_full & ~pop;

    // Lane counter runs alongside col; IMG_WIDTH being a multiple of PACK keeps them in step.
    always_comb begin
        lane_d = last_lane ? '0 : lane_q + LANE_W'(1);
        col_d  = col_last ? '0 : col_q + COL_W'(1);
        row_d  = row_q;
        if (col_last) row_d = row_last ? '0 : row_q + ROW_W'(1);
    end

    generate
        for (genvar gi = 0; gi < PACK - 1; gi++) begin : g_hold
            assign word[gi*DATA_WIDTH +: DATA_WIDTH] = hold_q[gi];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    hold_q[gi] <= '0;
                else if (clr)
                    hold_q[gi] <= '0;
                else if (pix_in_en && lane_q == LANE_W'(gi))
                    hold_q[gi] <= pix_in;
            end
        end
    endgenerate
    assign word[(PACK-1)*DATA_WIDTH +: DATA_WIDTH] = pix_in;

    always_comb begin
        wdata                 = '0;
        wdata[WORD_W-1:0]     = word;
        wdata[WORD_W+TAG_SOF] = (row_q == '0) && (col_q == COL_W'(PACK - 1));
        wdata[WORD_W+TAG_EOL] = col_last;
        wdata[WORD_W+TAG_EOF] = col_last & row_last;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q        <= '0;
            row_q        <= '0;
            lane_q       <= '0;
            overflow_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else if (clr) begin
            col_q        <= '0;
            row_q        <= '0;
            lane_q       <= '0;
            overflow_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            if (pix_in_en) begin
                col_q  <= col_d;
                row_q  <= row_d;
                lane_q <= lane_d;
            end
            if (drop) overflow_q <= 1'b1;
            frame_done_q <= pop & m_eof;
        end
    end

`ifdef PACKER_DROP_CNT_EN
    logic [15:0] drop_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            drop_cnt_q <= '0;
        else if (clr)
            drop_cnt_q <= '0;
        else if (drop && drop_cnt_q != 16'hFFFF)
            drop_cnt_q <= drop_cnt_q + 16'd1;
    end
    assign drop_cnt = drop_cnt_q;
`endif

    pack_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .push  (push_req),
        .pop   (pop),
        .wdata (wdata),
        .rdata (rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign m_valid    = ~fifo_empty;
    assign m_data     = rdata[WORD_W-1:0];
    assign m_sof      = rdata[WORD_W+TAG_SOF];
    assign m_eol      = rdata[WORD_W+TAG_EOL];
    assign m_eof      = rdata[WORD_W+TAG_EOF];
    assign overflow   = overflow_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_pixel_stream_packer.sv
// Scoreboard bench for pixel_stream_packer on an 8x2 frame with a 2-entry FIFO;
// stimulus queues expected words, a negedge monitor compares every popped word.
module tb_pixel_stream_packer;

    localparam int DW = 8;
    localparam int PK = 4;
    localparam int IW = 8;
    localparam int IH = 2;
    localparam int FD = 2;

    logic           clk;
    logic           rst_n;
    logic           clr;
    logic [DW-1:0]  pix_in;
    logic           pix_in_en;
    logic [PK*DW-1:0] m_data;
    logic           m_sof, m_eol, m_eof, m_valid, m_ready;
    logic           overflow, frame_done;
`ifdef PACKER_DROP_CNT_EN
    logic [15:0]    drop_cnt;
`endif

    pixel_stream_packer #(
        .DATA_WIDTH (DW),
        .PACK       (PK),
        .IMG_WIDTH  (IW),
        .IMG_HEIGHT (IH),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (clr),
        .pix_in     (pix_in),
        .pix_in_en  (pix_in_en),
        .m_data     (m_data),
        .m_sof      (m_sof),
        .m_eol      (m_eol),
        .m_eof      (m_eof),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .overflow   (overflow),
        .frame_done (frame_done)
`ifdef PACKER_DROP_CNT_EN
        ,
        .drop_cnt   (drop_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] data;
        logic        sof;
        logic        eol;
        logic        eof;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   fd_cnt   = 0;
    bit   rnd_ready = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: pops the scoreboard on every accepted word, counts frame_done pulses.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && frame_done) fd_cnt++;
            if (rst_n && m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_word actual=%h required=none", m_data);
                end else begin
                    e = exp_q.pop_front();
                    $display("word data=%h sof=%0b eol=%0b eof=%0b", m_data, m_sof, m_eol, m_eof);
                    check("word_data", m_data, e.data);
                    check("word_tags", {29'd0, m_sof, m_eol, m_eof}, {29'd0, e.sof, e.eol, e.eof});
                end
            end
        end
    end

    // Random ready, never low two cycles running so a 2-deep FIFO cannot overflow.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd_ready) m_ready = m_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_pix(input logic [7:0] v);
        pix_in    = v;
        pix_in_en = 1'b1;
        @(posedge clk);
        #1;
        pix_in_en = 1'b0;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
    endtask

    task automatic expw(input logic [31:0] d, input logic s, input logic l, input logic f);
        exp_t e;
        e.data = d;
        e.sof  = s;
        e.eol  = l;
        e.eof  = f;
        exp_q.push_back(e);
    endtask

    task automatic exp_frame(input logic [7:0] base);
        logic [7:0] b;
        for (int w = 0; w < 4; w++) begin
            b = base + 8'(4 * w);
            expw({b + 8'd3, b + 8'd2, b + 8'd1, b}, w == 0, (w % 2) == 1, w == 3);
        end
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 64 && (m_valid || exp_q.size() != 0); i++) idle(1);
        check({name, "_queue_empty"}, exp_q.size(), 0);
        check({name, "_valid_low"}, {31'd0, m_valid}, 0);
    endtask

    initial begin
        int fd0;
        rst_n     = 1'b0;
        clr       = 1'b0;
        pix_in    = '0;
        pix_in_en = 1'b0;
        m_ready   = 1'b0;
        idle(3);
        check("reset_valid", {31'd0, m_valid}, 0);
        check("reset_data", m_data, 0);
        check("reset_tags", {29'd0, m_sof, m_eol, m_eof}, 0);
        check("reset_overflow", {31'd0, overflow}, 0);
        check("reset_frame_done", {31'd0, frame_done}, 0);
`ifdef PACKER_DROP_CNT_EN
        check("reset_drop_cnt", {16'd0, drop_cnt}, 0);
`endif
        rst_n = 1'b1;
        idle(1);

        // Back-to-back frame, always ready.
        m_ready = 1'b1;
        fd0 = fd_cnt;
        exp_frame(8'h01);
        for (int i = 0; i < 16; i++) send_pix(8'(1 + i));
        drain("b2b");
        idle(2);
        check("b2b_frame_done", fd_cnt - fd0, 1);
        check("b2b_overflow", {31'd0, overflow}, 0);

        // Same frame with input gaps and random ready.
        rnd_ready = 1'b1;
        fd0 = fd_cnt;
        exp_frame(8'h01);
        for (int i = 0; i < 16; i++) begin
            send_pix(8'(1 + i));
            idle($urandom_range(0, 2));
        end
        rnd_ready = 1'b0;
        m_ready   = 1'b1;
        drain("gaps");
        idle(2);
        check("gaps_frame_done", fd_cnt - fd0, 1);
        check("gaps_overflow", {31'd0, overflow}, 0);

        // FIFO full, ready pulsed on the cycle of the third push.
        m_ready = 1'b0;
        fd0 = fd_cnt;
        exp_frame(8'h01);
        for (int i = 0; i < 11; i++) send_pix(8'(1 + i));
        check("full_head_data", m_data, 32'h04030201);
        m_ready = 1'b1;
        for (int i = 11; i < 16; i++) send_pix(8'(1 + i));
        drain("fullpop");
        idle(2);
        check("fullpop_overflow", {31'd0, overflow}, 0);
        check("fullpop_frame_done", fd_cnt - fd0, 1);

        // Overflow: whole frame with ready low, two words kept, two dropped.
        m_ready = 1'b0;
        expw(32'h04030201, 1'b1, 1'b0, 1'b0);
        expw(32'h08070605, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 16; i++) send_pix(8'(1 + i));
        check("ovf_valid", {31'd0, m_valid}, 1);
        check("ovf_head_data", m_data, 32'h04030201);
        check("ovf_head_sof", {31'd0, m_sof}, 1);
        check("ovf_overflow", {31'd0, overflow}, 1);
`ifdef PACKER_DROP_CNT_EN
        check("ovf_drop_cnt", {16'd0, drop_cnt}, 2);
`endif
        fd0 = fd_cnt;
        m_ready = 1'b1;
        drain("ovf");
        idle(2);
        check("ovf_no_frame_done", fd_cnt - fd0, 0);
        exp_frame(8'h21);
        for (int i = 0; i < 16; i++) send_pix(8'(8'h21 + i));
        drain("ovf_next");
        check("ovf_sticky", {31'd0, overflow}, 1);

        // clr discards a partial word and clears overflow.
        do_clr();
        exp_q.delete();
        check("clr_overflow", {31'd0, overflow}, 0);
`ifdef PACKER_DROP_CNT_EN
        check("clr_drop_cnt", {16'd0, drop_cnt}, 0);
`endif
        for (int i = 0; i < 3; i++) send_pix(8'(1 + i));
        do_clr();
        expw(32'hADACABAA, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) send_pix(8'(8'hAA + i));
        drain("clr");

        // Asynchronous reset mid-line while a word is waiting.
        m_ready = 1'b0;
        for (int i = 0; i < 6; i++) send_pix(8'(8'h31 + i));
        check("prerst_valid", {31'd0, m_valid}, 1);
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        check("arst_valid", {31'd0, m_valid}, 0);
        check("arst_data", m_data, 0);
        check("arst_tags", {29'd0, m_sof, m_eol, m_eof}, 0);
        check("arst_frame_done", {31'd0, frame_done}, 0);
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        m_ready = 1'b1;
        expw(32'h44434241, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) send_pix(8'(8'h41 + i));
        drain("arst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
